// File: rtl/mux_if.sv
// mux_if: operand/select inputs and result/status outputs of the mux block
interface mux_if #(parameter int WIDTH = 1, parameter int CNT_W = 8);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic sel;
  logic in_valid;
  logic sel_lock;
  logic out_valid;
  logic sel_q;
  logic [CNT_W-1:0] sw_cnt;
  modport master(output a, b, sel, in_valid, sel_lock, input y, y_q, out_valid, sel_q, sw_cnt);
  modport slave(input a, b, sel, in_valid, sel_lock, output y, y_q, out_valid, sel_q, sw_cnt);
endinterface

// File: rtl/mux.sv
// mux: 2:1 selector with combinational output plus registered, lockable, switch-counted copy
module mux #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  mux_if.slave bus
);
  logic eff_sel;
  assign bus.y = bus.sel ? bus.b : bus.a;
  assign eff_sel = bus.sel_lock ? bus.sel_q : bus.sel;
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.y_q <= {WIDTH{1'b0}};
      bus.out_valid <= 1'b0;
      bus.sel_q <= 1'b0;
      bus.sw_cnt <= {CNT_W{1'b0}};
    end else if (bus.in_valid) begin
      bus.y_q <= eff_sel ? bus.b : bus.a;
      bus.out_valid <= 1'b1;
      if (!bus.sel_lock) bus.sel_q <= bus.sel;
      if (!bus.sel_lock && bus.sel != bus.sel_q && bus.sw_cnt != {CNT_W{1'b1}})
        bus.sw_cnt <= bus.sw_cnt + 1'b1;
    end else begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux.sv
// tb_mux: directed plus random stimulus against a behavioural model, on an 8-bit and a 2-bit counter instance
module tb_mux;
  logic clk = 0;
  logic rn, a, b, sel, iv, lk;
  int n_chk = 0, n_fail = 0;
  logic m_yq, m_ov, m_sq;
  int c0, c1;
  mux_if #(.WIDTH(1), .CNT_W(8)) i0();
  mux_if #(.WIDTH(1), .CNT_W(2)) i1();
  mux #(.WIDTH(1), .CNT_W(8)) u0(.clk(clk), .rst(rn), .bus(i0.slave));
  mux #(.WIDTH(1), .CNT_W(2)) u1(.clk(clk), .rst(rn), .bus(i1.slave));
  assign {i0.a, i0.b, i0.sel, i0.in_valid, i0.sel_lock} = {a, b, sel, iv, lk};
  assign {i1.a, i1.b, i1.sel, i1.in_valid, i1.sel_lock} = {a, b, sel, iv, lk};
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic es;
    @(posedge clk);
    if (!rn) begin
      {m_yq, m_ov, m_sq} = 3'b000;
      c0 = 0;
      c1 = 0;
    end else if (iv) begin
      es = lk ? m_sq : sel;
      if (!lk && sel != m_sq) begin
        c0 = (c0 < 255) ? c0 + 1 : 255;
        c1 = (c1 < 3) ? c1 + 1 : 3;
      end
      m_yq = es ? b : a;
      m_ov = 1'b1;
      if (!lk) m_sq = sel;
    end else begin
      m_ov = 1'b0;
    end
    @(negedge clk);
    chk("y0", i0.y, sel ? b : a);
    chk("y1", i1.y, sel ? b : a);
    chk("yq0", i0.y_q, m_yq);
    chk("yq1", i1.y_q, m_yq);
    chk("ov0", i0.out_valid, m_ov);
    chk("ov1", i1.out_valid, m_ov);
    chk("sq0", i0.sel_q, m_sq);
    chk("sq1", i1.sel_q, m_sq);
    chk("cnt0", i0.sw_cnt, c0);
    chk("cnt1", i1.sw_cnt, c1);
  endtask

  task automatic drv(input logic r, input logic v, input logic l, input logic s, input logic aa, input logic bb);
    {rn, iv, lk, sel, a, b} = {r, v, l, s, aa, bb};
  endtask

  initial begin
    logic [7:0] tt;
    tt = 8'b11011000;
    drv(0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("rst_yq", i0.y_q, 0);
    chk("rst_ov", i0.out_valid, 0);
    chk("rst_cnt", i0.sw_cnt, 0);
    for (int i = 0; i < 8; i++) begin
      drv(1, 0, 0, i[0], i[2], i[1]);
      @(posedge clk);
      @(negedge clk);
      chk("tt", i0.y, tt[i]);
    end
    drv(0, 0, 0, 0, 0, 0);
    step();
    step();
    drv(1, 1, 0, 0, 1, 0);
    step();
    chk("reg_yq", i0.y_q, 1);
    chk("reg_ov", i0.out_valid, 1);
    chk("reg_cnt", i0.sw_cnt, 0);
    drv(1, 1, 0, 1, 1, 0);
    step();
    chk("sw_yq", i0.y_q, 0);
    chk("sw_cnt", i0.sw_cnt, 1);
    drv(1, 1, 1, 0, 1, 0);
    step();
    chk("lock_yq", i0.y_q, 0);
    chk("lock_cnt", i0.sw_cnt, 1);
    drv(1, 1, 0, 0, 1, 0);
    step();
    chk("rel_yq", i0.y_q, 1);
    chk("rel_cnt", i0.sw_cnt, 2);
    for (int i = 0; i < 3; i++) begin
      drv(1, 0, 0, i[0], 0, 1);
      step();
      chk("gap_ov", i0.out_valid, 0);
      chk("gap_yq", i0.y_q, 1);
      chk("gap_cnt", i0.sw_cnt, 2);
    end
    drv(0, 1, 0, 1, 0, 1);
    step();
    chk("mid_yq", i0.y_q, 0);
    chk("mid_ov", i0.out_valid, 0);
    chk("mid_sq", i0.sel_q, 0);
    chk("mid_cnt", i0.sw_cnt, 0);
    drv(1, 1, 1, 1, 1, 0);
    step();
    chk("lock_first", i0.y_q, 1);
    for (int i = 0; i < 5; i++) begin
      drv(1, 1, 0, ~i[0], 0, 1);
      step();
    end
    chk("sat1", i1.sw_cnt, 3);
    chk("sat0", i0.sw_cnt, 5);
    for (int i = 0; i < 400; i++) begin
      drv($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
          1'($urandom), 1'($urandom), 1'($urandom));
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mux.md
Name: mux

Overview:
- 2:1 multiplexer of WIDTH-bit operands, with a zero-latency combinational output and a registered, valid-qualified copy.
- Includes a select-lock feature and a select-switch counter.
- Used as a leaf datapath selector; the combinational path is exhaustively checked against an 8-entry truth table {a,b,sel,y}.

Parameters:
- WIDTH, 1, bit width of a, b, y, y_q.
- CNT_W, 8, width of the select-switch counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-low (asserted when 0, sampled on rising clk).
- a  input  WIDTH  operand selected when effective select = 0.
- b  input  WIDTH  operand selected when effective select = 1.
- sel  input  1  select request.
- in_valid  input  1  qualifies a/b/sel for the registered path.
- sel_lock  input  1  when 1, the registered path keeps using the last latched select.
- y  output  WIDTH  combinational result: sel ? b : a.
- y_q  output  WIDTH  registered result.
- out_valid  output  1  y_q holds a valid result.
- sel_q  output  1  latched select used by the registered path.
- sw_cnt  output  CNT_W  number of accepted select changes.

Behaviour:
- Combinational y:
  - y = sel ? b : a, bitwise across WIDTH.
  - Independent of clk, rst, in_valid and sel_lock; zero latency.
  - X/Z on sel must not be masked: y follows ordinary conditional-operator semantics.
- Reset (rst=0 at a rising clk): y_q=0, out_valid=0, sel_q=0, sw_cnt=0. Reset dominates all other events in the same cycle.
- Registered path, on each rising clk with rst=1:
  - eff_sel = sel_lock ? sel_q : sel.
  - If in_valid=1:
    - y_q <= eff_sel ? b : a; out_valid <= 1.
    - If sel_lock=0, sel_q <= sel.
    - If sel_lock=0 and sel != sel_q, sw_cnt <= sw_cnt+1.
  - If in_valid=0: y_q and sel_q hold; out_valid <= 0; sw_cnt holds.
- Latency: y_q/out_valid reflect inputs sampled at edge N, visible after edge N (1 cycle).
- sw_cnt:
  - Saturates at all-ones and does not wrap.
  - A select change while sel_lock=1 is not counted.
  - Releasing the lock with a different sel and in_valid=1 counts once.
- Reset asserted mid-stream: out_valid drops to 0 on that edge; the next valid sample after reset releases uses sel_q=0 as the prior select for change counting.
- Simultaneous sel_lock=1 and in_valid=1 at the first cycle after reset: eff_sel=0, so y_q=a.
- No internal state affects y; registered outputs never glitch between edges.

Test Plan:
- Truth table, WIDTH=1, rst=1, combinational: {a,b,sel} = 000,010,100,110 -> y=0,0,1,1; {a,b,sel} = 001,011,101,111 -> y=0,1,0,1. Settle y at each posedge and check before the next one; zero mismatches required.
- Registered path: rst=0 for 2 cycles, then in_valid=1, a=1, b=0, sel=0 -> one edge later y_q=1, out_valid=1, sel_q=0, sw_cnt=0; then sel=1 -> y_q=0, sw_cnt=1.
- Lock: sel_q=1 latched, sel_lock=1, sel=0, a=1, b=0 -> y_q=0 (b), sw_cnt unchanged; release lock with sel=0 -> y_q=1, sw_cnt +1.
- Valid gap: in_valid=0 for 3 cycles -> out_valid=0, y_q held, sw_cnt held while sel toggles.
- Saturation, CNT_W=2: 5 alternating valid selects -> sw_cnt stops at 3.
- Reset mid-operation: rst=0 while out_valid=1 and sw_cnt=2 -> next edge all registered outputs 0; y still equals sel?b:a throughout.
